// File: rtl/conv1d_seq_ctrl.sv
// conv1d_seq_ctrl: sequencer for a K-tap 1-D convolution systolic array.
// It loads K tap weights into a bank, streams sig_len samples into the array
// head, drops the K-1 warm-up results from the array tail, and forwards the
// remaining results with a last flag.
// Optional: define CONV_SEQ_CTRL_PERF_EN to add the perf_cycles/perf_stall
// counters.
module conv1d_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int K          = 3,
  parameter int LEN_W      = 10,
  parameter int PE_LAT     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        sig_len,
  input  logic                    w_valid,
  input  logic [DATA_WIDTH-1:0]   w_data,
  output logic                    w_ready,
  input  logic                    x_valid,
  input  logic [DATA_WIDTH-1:0]   x_data,
  output logic                    x_ready,
  output logic                    arr_valid,
  output logic [DATA_WIDTH-1:0]   arr_data,
  output logic [K*DATA_WIDTH-1:0] arr_weight,
  input  logic                    arr_res_valid,
  input  logic [15:0]             arr_res,
  output logic                    y_valid,
  output logic [15:0]             y_data,
  output logic                    y_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err
`ifdef CONV_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]             perf_cycles,
  output logic [31:0]             perf_stall
`endif
);

  // Reject unsupported configurations at elaboration time.
  if (K < 2 || K > 16 || PE_LAT < 1) begin : g_bad_param
    $error("conv1d_seq_ctrl: K must be 2..16 and PE_LAT >= 1");
  end

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  localparam int WC_W = $clog2(K);

  state_t                         state;
  logic [LEN_W-1:0]               len;
  logic [LEN_W-1:0]               issued;
  logic [LEN_W-1:0]               rcv;
  logic [WC_W-1:0]                w_cnt;
  logic [K-1:0][DATA_WIDTH-1:0]   w_bank;

  logic len_bad, start_ok, w_hs, x_hs, res_act, warm;

  // A length shorter than the tap count yields no valid output at all.
  assign len_bad  = (sig_len < LEN_W'(K)) || (sig_len == '0);
  assign start_ok = (state == IDLE) && start && !len_bad;
  assign w_ready  = (state == LOAD_W);
  // issued < len always holds in STREAM; the compare just makes the intent explicit.
  assign x_ready  = (state == STREAM) && (issued < len);
  assign busy     = (state != IDLE);
  assign w_hs     = w_valid && w_ready;
  assign x_hs     = x_valid && x_ready;
  assign res_act  = arr_res_valid && ((state == STREAM) || (state == DRAIN));
  assign warm     = (rcv < LEN_W'(K - 1));
  assign arr_weight = w_bank;

  // Control FSM: length latch, weight/sample counters, done/err pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      len    <= '0;
      w_cnt  <= '0;
      issued <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len <= sig_len;
            if (len_bad) begin
              err <= 1'b1;
            end else begin
              state  <= LOAD_W;
              w_cnt  <= '0;
              issued <= '0;
            end
          end
        end
        LOAD_W: begin
          if (w_hs) begin
            if (w_cnt == WC_W'(K - 1)) state <= STREAM;
            else                       w_cnt <= w_cnt + WC_W'(1);
          end
        end
        STREAM: begin
          if (x_hs) begin
            issued <= issued + LEN_W'(1);
            if ((issued + LEN_W'(1)) == len) state <= DRAIN;
          end
        end
        DRAIN: begin
          // y_last is on the outputs this cycle; completion follows it.
          if (y_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Weight bank: tap w_cnt captures each accepted weight word; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_bank <= '0;
    end else begin
      for (int i = 0; i < K; i++) begin
        if (w_hs && (w_cnt == WC_W'(i))) w_bank[i] <= w_data;
      end
    end
  end

  // Array head: register accepted samples; data holds when no sample moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_valid <= 1'b0;
      arr_data  <= '0;
    end else begin
      arr_valid <= x_hs;
      if (x_hs) arr_data <= x_data;
    end
  end

  // Result path: count tail results, drop warm-up, forward the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcv     <= '0;
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      y_last  <= 1'b0;
      if (start_ok) begin
        rcv <= '0;
      end else if (res_act) begin
        rcv <= rcv + LEN_W'(1);
        if (!warm) begin
          y_valid <= 1'b1;
          y_data  <= arr_res;
          // Result index len-1 is output number len-K+1, the final one.
          y_last  <= (rcv == (len - LEN_W'(1)));
        end
      end
    end
  end

`ifdef CONV_SEQ_CTRL_PERF_EN
  // Perf counters: restart on an accepted start, freeze once back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (start_ok) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if ((state == STREAM) && x_ready && !x_valid) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv1d_seq_ctrl.sv
// Self-checking bench for conv1d_seq_ctrl (K=3, LEN_W=10). A behavioural
// array model feeds psums back to the DUT; expected outputs come from the
// convolution definition applied to the bench's own weights and samples.
module tb_conv1d_seq_ctrl;
  localparam int DW = 8, K = 3, LEN_W = 10, PE_LAT = 2, LAT = K * PE_LAT;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [LEN_W-1:0]  sig_len = '0;
  logic              w_valid = 1'b0, x_valid = 1'b0;
  logic [DW-1:0]     w_data = '0, x_data = '0;
  logic              w_ready, x_ready, arr_valid, y_valid, y_last, busy, done, err;
  logic [DW-1:0]     arr_data;
  logic [K*DW-1:0]   arr_weight;
  logic              arr_res_valid = 1'b0;
  logic [15:0]       arr_res = '0;
  logic [15:0]       y_data;

  always #5 clk = ~clk;

  conv1d_seq_ctrl #(.DATA_WIDTH(DW), .K(K), .LEN_W(LEN_W), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sig_len(sig_len),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .arr_valid(arr_valid), .arr_data(arr_data), .arr_weight(arr_weight),
    .arr_res_valid(arr_res_valid), .arr_res(arr_res),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last),
    .busy(busy), .done(done), .err(err)
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stimulus data owned by the bench.
  logic [DW-1:0] w_tb [K];
  logic [DW-1:0] x_tb [$];
  int run_id = 0;

  function automatic logic [15:0] ref_y(input int j);
    int unsigned acc = 0;
    for (int k = 0; k < K; k++) acc += w_tb[k] * x_tb[j + k];
    return acc[15:0];
  endfunction

  // Array model: fixed K*PE_LAT delay; result e is the K-tap window ending at
  // sample e, warm-up results are garbage.
  logic [DW-1:0]  hist [$];
  logic [LAT-1:0] pipe = '0;
  int             emit = 0, seen_id = 0;

  function automatic logic [15:0] psum(input int e);
    int unsigned acc = 0;
    if (e < K - 1) return 16'($urandom);
    for (int k = 0; k < K; k++) acc += arr_weight[k*DW +: DW] * hist[e - K + 1 + k];
    return acc[15:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_n || seen_id != run_id) begin
      pipe = '0;
      hist.delete();
      emit = 0;
      seen_id = run_id;
      arr_res_valid = 1'b0;
    end else begin
      if (arr_valid) hist.push_back(arr_data);
      arr_res_valid = pipe[LAT-1];
      if (pipe[LAT-1]) begin
        arr_res = psum(emit);
        emit++;
      end
      pipe = {pipe[LAT-2:0], arr_valid};
    end
  end

  // Output monitor.
  logic [15:0] yq [$];
  bit          lq [$];
  int cyc = 0, last_cyc = 0, done_cyc = 0, done_cnt = 0, err_cnt = 0, arr_cnt = 0, stray = 0;

  always @(negedge clk) begin
    cyc++;
    if (y_valid) begin
      yq.push_back(y_data);
      lq.push_back(y_last);
    end
    if (y_last) last_cyc = cyc;
    if (y_last && !y_valid) stray++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
    if (arr_valid) arr_cnt++;
  end

  task automatic fill(input int len, input bit ramp);
    x_tb.delete();
    for (int i = 0; i < len; i++) x_tb.push_back(ramp ? DW'(i + 1) : DW'($urandom));
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {w_ready, x_ready, arr_valid, arr_data, arr_weight, y_valid, y_data,
              y_last, busy, done, err}, 64'd0);
  endtask

  // One transfer: start, load weights, stream samples, wait for done, check.
  // mode 0 back-to-back, 1 valid pattern 1,0,0,..., 2 random valid.
  task automatic run(input int len, input int mode, input bit poke_start, input int abort_at);
    int y0, d0, e0, a0, i, t, n_out, got;
    logic rdy, v;
    logic [K*DW-1:0] expw;
    y0 = yq.size(); d0 = done_cnt; e0 = err_cnt; a0 = arr_cnt;
    run_id++;
    start = 1'b1; sig_len = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0; sig_len = LEN_W'($urandom);
    chk("busy_after_start", busy, 1);

    i = 0; t = 0;
    while (i < K && t < 200) begin
      v = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      w_valid = v; w_data = w_tb[i]; rdy = w_ready;
      @(posedge clk); #1;
      if (v && rdy) i++;
      t++;
    end
    w_valid = 1'b0;
    for (int k = 0; k < K; k++) expw[k*DW +: DW] = w_tb[k];
    chk("weight_bank", arr_weight, expw);
    chk("w_ready_after_load", w_ready, 0);

    i = 0; t = 0;
    while (i < len && t < 20 * len + 100) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (t % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      x_valid = v; x_data = v ? x_tb[i] : DW'($urandom);
      rdy = x_ready;
      if (mode == 1) chk("x_ready_held", rdy, 1);
      if (poke_start && i == 2) begin start = 1'b1; sig_len = LEN_W'(9); end
      @(posedge clk); #1;
      start = 1'b0;
      if (v && rdy) i++;
      t++;
      if (abort_at != 0 && i == abort_at) break;
    end
    x_valid = 1'b0;
    if (abort_at != 0) return;
    chk("x_ready_after_stream", x_ready, 0);

    t = 0;
    while (done_cnt == d0 && t < 4 * len + 4 * LAT + 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_after_done", busy, 0);
    n_out = len - K + 1;
    got = yq.size() - y0;
    chk("y_count", got, n_out);
    for (int j = 0; j < got && j < n_out; j++) begin
      chk("y_data", yq[y0 + j], ref_y(j));
      chk("y_last", lq[y0 + j], (j == n_out - 1));
    end
    chk("done_after_last", done_cyc - last_cyc, 1);
    chk("arr_beats", arr_cnt - a0, len);
    chk("no_err", err_cnt - e0, 0);
  endtask

  task automatic bad_start(input int len);
    int e0;
    e0 = err_cnt;
    start = 1'b1; sig_len = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("bad_busy", busy, 0);
    chk("bad_w_ready", w_ready, 0);
    @(posedge clk); #1;
    chk("err_one_cycle", err, 0);
    chk("err_count", err_cnt - e0, 1);
    chk("bad_still_idle", busy, 0);
  endtask

  task automatic chk_nominal(input int base);
    if (yq.size() >= base + 3) begin
      chk("nom_y0", yq[base], 16'd14);
      chk("nom_y1", yq[base + 1], 16'd20);
      chk("nom_y2", yq[base + 2], 16'd26);
      chk("nom_last", lq[base + 2], 1);
    end else begin
      chk("nom_beats", yq.size() - base, 3);
    end
  endtask

  initial begin
    int base, len, mode;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal run: weights 1,2,3, samples 1..5.
    w_tb[0] = 8'd1; w_tb[1] = 8'd2; w_tb[2] = 8'd3;
    fill(5, 1);
    base = yq.size();
    run(5, 0, 0, 0);
    chk_nominal(base);

    // Rejected lengths.
    bad_start(2);
    bad_start(0);

    // Source stalls: identical outputs expected.
    base = yq.size();
    run(5, 1, 0, 0);
    chk_nominal(base);

    // Reset after 3 samples issued.
    run(5, 0, 0, 3);
    rst_n = 1'b0;
    #1;
    chk_reset("reset_mid_stream");
    base = yq.size();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("no_y_after_reset", yq.size() - base, 0);
    base = yq.size();
    run(5, 0, 0, 0);
    chk_nominal(base);

    // Start during STREAM is ignored; original length of 5 holds.
    base = yq.size();
    run(5, 0, 1, 0);
    chk_nominal(base);

    // Shortest legal length.
    fill(K, 0);
    run(K, 0, 0, 0);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < K; k++) w_tb[k] = DW'($urandom);
      len  = $urandom_range(K, 40);
      mode = $urandom_range(0, 2);
      fill(len, 0);
      run(len, mode, 0, 0);
    end

    // Maximum length.
    for (int k = 0; k < K; k++) w_tb[k] = DW'($urandom);
    fill(1023, 0);
    run(1023, 0, 0, 0);

    chk("stray_y_last", stray, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
